wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 185 ++++++++++++++++++
 tb/tb_wb_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: selects ALU, load or PC+4 result and drives the register-file write port.
// Optional instret counter when WB_INSTRET_EN is defined.
module wb_stage (
    input  logic        clk,
    input  logic        rest,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd_a,
    input  logic [1:0]  in_wb_sel,
    input  logic [31:0] in_alu_dt,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        we,
    output logic [4:0]  rd_a,
    output logic [31:0] rd_dt,
    output logic        retire
`ifdef WB_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_NONE = 2'b11;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [4:0]  r_ld_rd;
    logic [2:0]  r_ld_f3;
    logic [1:0]  r_ld_lo;

    logic        r_we;
    logic        r_retire;
    logic [4:0]  r_rd_a;
    logic [31:0] r_rd_dt;

    logic        w_ready;
    logic        w_acc;
    logic        w_we_nxt;
    logic        w_ret_nxt;
    logic [4:0]  w_rd_nxt;
    logic [31:0] w_dt_nxt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_dt;

    // State register
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, WRITE: begin
                if (w_acc) begin
                    w_state_nxt = (in_wb_sel == SEL_LOAD) ? WAIT_MEM : WRITE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_MEM: begin
                w_state_nxt = mem_rvalid ? WRITE : WAIT_MEM;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pick the addressed byte / halfword out of the aligned load word
    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_ld_lo)
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            2'd3: w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_ld_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    // Sign/zero extension by load type; unknown codes take the full word
    always_comb begin
        w_ld_dt = mem_rdata;
        case (r_ld_f3)
            3'b000:  w_ld_dt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_dt = {24'd0, w_byte};
            3'b001:  w_ld_dt = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_dt = {16'd0, w_half};
            default: w_ld_dt = mem_rdata;
        endcase
    end

    // Output logic: handshake and next values of the registered write port
    always_comb begin
        w_ready   = (r_state != WAIT_MEM);
        w_acc     = in_valid && w_ready;
        w_we_nxt  = 1'b0;
        w_ret_nxt = 1'b0;
        w_rd_nxt  = r_rd_a;
        w_dt_nxt  = r_rd_dt;
        if (r_state == WAIT_MEM) begin
            if (mem_rvalid) begin
                w_ret_nxt = 1'b1;
                w_we_nxt  = (r_ld_rd != 5'd0);
                w_rd_nxt  = r_ld_rd;
                w_dt_nxt  = w_ld_dt;
            end
        end else if (w_acc && (in_wb_sel != SEL_LOAD)) begin
            w_ret_nxt = 1'b1;
            w_we_nxt  = (in_rd_a != 5'd0) && (in_wb_sel != SEL_NONE);
            if (in_wb_sel != SEL_NONE) begin
                w_rd_nxt = in_rd_a;
                w_dt_nxt = (in_wb_sel == SEL_ALU) ? in_alu_dt
                                                  : in_pc + 32'd4;
            end
        end
    end

    // Capture load context at accept; it is used when the data returns
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_ld_rd <= 5'd0;
            r_ld_f3 <= 3'd0;
            r_ld_lo <= 2'd0;
        end else if (w_acc && (in_wb_sel == SEL_LOAD)) begin
            r_ld_rd <= in_rd_a;
            r_ld_f3 <= in_funct3;
            r_ld_lo <= in_addr_lo;
        end
    end

    // Registered write port and retire pulse
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_we     <= 1'b0;
            r_retire <= 1'b0;
            r_rd_a   <= 5'd0;
            r_rd_dt  <= 32'd0;
        end else begin
            r_we     <= w_we_nxt;
            r_retire <= w_ret_nxt;
            r_rd_a   <= w_rd_nxt;
            r_rd_dt  <= w_dt_nxt;
        end
    end

`ifdef WB_INSTRET_EN
    logic [31:0] r_instret;

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_instret <= 32'd0;
        end else if (r_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`endif

    assign in_ready = w_ready;
    assign we       = r_we;
    assign retire   = r_retire;
    assign rd_a     = r_rd_a;
    assign rd_dt    = r_rd_dt;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vectors plus random traffic
// against a transaction-level reference model.
module tb_wb_stage;

    logic        clk;
    logic        rest;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd_a;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_dt;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        we;
    logic [4:0]  rd_a;
    logic [31:0] rd_dt;
    logic        retire;
`ifdef WB_INSTRET_EN
    logic [31:0] instret;
`endif

    int n_chk;
    int n_fail;

    // Reference model: one outstanding load at most, plus retire count
    bit          m_wait;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_lo;
    int unsigned m_ret;

    wb_stage dut (
        .clk        (clk),
        .rest       (rest),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd_a    (in_rd_a),
        .in_wb_sel  (in_wb_sel),
        .in_alu_dt  (in_alu_dt),
        .in_pc      (in_pc),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .we         (we),
        .rd_a       (rd_a),
        .rd_dt      (rd_dt),
        .retire     (retire)
`ifdef WB_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [1:0] lo,
                                             input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * lo[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rest       = 1'b0;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        m_wait     = 0;
        m_ret      = 0;
        #1;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_rd_a", {27'd0, rd_a}, 32'd0);
        chk("rst_rd_dt", rd_dt, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
`ifdef WB_INSTRET_EN
        chk("rst_instret", instret, 32'd0);
`endif
        @(negedge clk);
        rest = 1'b1;
    endtask

    // One clock cycle: drive inputs, predict, clock, compare
    task automatic step(input logic v, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] f3,
                        input logic [1:0] lo, input logic rv,
                        input logic [31:0] rdat);
        bit          e_ret;
        bit          e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_dt;
        @(negedge clk);
        in_valid   = v;
        in_rd_a    = rd;
        in_wb_sel  = sel;
        in_alu_dt  = alu;
        in_pc      = pc;
        in_funct3  = f3;
        in_addr_lo = lo;
        mem_rvalid = rv;
        mem_rdata  = rdat;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_wait});
        e_ret = 0;
        e_we  = 0;
        e_rd  = 5'd0;
        e_dt  = 32'd0;
        if (m_wait) begin
            if (rv) begin
                e_ret  = 1;
                e_we   = (m_rd != 0);
                e_rd   = m_rd;
                e_dt   = ref_load(m_f3, m_lo, rdat);
                m_wait = 0;
            end
        end else if (v) begin
            if (sel == 2'b01) begin
                m_wait = 1;
                m_rd   = rd;
                m_f3   = f3;
                m_lo   = lo;
            end else begin
                e_ret = 1;
                e_we  = (sel != 2'b11) && (rd != 0);
                e_rd  = rd;
                e_dt  = (sel == 2'b00) ? alu : pc + 4;
            end
        end
        @(posedge clk);
        #1;
        chk("we", {31'd0, we}, {31'd0, e_we});
        chk("retire", {31'd0, retire}, {31'd0, e_ret});
        if (e_we) begin
            chk("rd_a", {27'd0, rd_a}, {27'd0, e_rd});
            chk("rd_dt", rd_dt, e_dt);
        end
`ifdef WB_INSTRET_EN
        chk("instret", instret, m_ret);
`endif
        if (e_ret) m_ret++;
    endtask

    task automatic idle(input logic rv);
        step(1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 3'd0, 2'd0, rv, $urandom);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rest       = 1'b0;
        in_valid   = 1'b0;
        in_rd_a    = 5'd0;
        in_wb_sel  = 2'b00;
        in_alu_dt  = 32'd0;
        in_pc      = 32'd0;
        in_funct3  = 3'd0;
        in_addr_lo = 2'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        m_wait     = 0;
        m_ret      = 0;
        repeat (2) @(posedge clk);
        do_reset();

        // ALU result
        step(1, 5'd5, 2'b00, 32'h12345678, 32'd0, 3'd0, 2'd0, 0, 32'd0);
        chk("alu_dt", rd_dt, 32'h12345678);
        chk("alu_rd", {27'd0, rd_a}, 32'd5);

        // LB at byte 3 after two wait cycles
        step(1, 5'd7, 2'b01, 32'd0, 32'd0, 3'b000, 2'd3, 0, 32'd0);
        idle(0);
        idle(0);
        step(0, 5'd0, 2'b00, 32'd0, 32'd0, 3'd0, 2'd0, 1, 32'h80FF7F01);
        chk("lb_dt", rd_dt, 32'hFFFFFF80);

        // LHU / LH upper halfword; rvalid in accept cycle is ignored
        step(1, 5'd8, 2'b01, 32'd0, 32'd0, 3'b101, 2'd2, 1, 32'hDEAD0000);
        step(0, 5'd0, 2'b00, 32'd0, 32'd0, 3'd0, 2'd0, 1, 32'hBEEF1234);
        chk("lhu_dt", rd_dt, 32'h0000BEEF);
        step(1, 5'd9, 2'b01, 32'd0, 32'd0, 3'b001, 2'd2, 0, 32'd0);
        step(0, 5'd0, 2'b00, 32'd0, 32'd0, 3'd0, 2'd0, 1, 32'hBEEF1234);
        chk("lh_dt", rd_dt, 32'hFFFFBEEF);

        // PC+4 wraps; x0 destination retires without writing
        step(1, 5'd1, 2'b10, 32'd0, 32'hFFFFFFFC, 3'd0, 2'd0, 0, 32'd0);
        chk("pc4_wrap", rd_dt, 32'h00000000);
        step(1, 5'd0, 2'b10, 32'd0, 32'hFFFFFFFC, 3'd0, 2'd0, 0, 32'd0);
        chk("pc4_x0_we", {31'd0, we}, 32'd0);
        chk("pc4_x0_ret", {31'd0, retire}, 32'd1);

        // Back-to-back ALU ops from a fresh reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 5'(i + 2), 2'b00, 32'(i * 3 + 11), 32'd0,
                 3'd0, 2'd0, 0, 32'd0);
        end
        idle(0);
`ifdef WB_INSTRET_EN
        chk("instret_3", instret, 32'd3);
`endif

        // Reset during WAIT_MEM drops the load
        step(1, 5'd4, 2'b01, 32'd0, 32'd0, 3'b010, 2'd0, 0, 32'd0);
        do_reset();
        idle(1);
        chk("rst_load_we", {31'd0, we}, 32'd0);
        chk("rst_load_rdy", {31'd0, in_ready}, 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic rv;
            rv = m_wait ? ($urandom_range(0, 2) == 0)
                        : ($urandom_range(0, 4) == 0);
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                 2'($urandom), $urandom, $urandom, 3'($urandom),
                 2'($urandom), rv, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
